// File: rtl/count_pwm.sv
// PWM generator slaved to an external 8-bit up/down counter, with IDLE/ARMED/RUN sequencing.
// Define COUNT_PWM_SAT_EN to make period_cnt saturate at 16'hFFFF instead of wrapping.
module count_pwm #(
  parameter logic POL = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  val,
  input  logic        crt,
  input  logic        en,
  input  logic [7:0]  duty_in,
  input  logic        duty_wr,
  output logic        pwm,
  output logic        period_done,
  output logic [15:0] period_cnt,
  output logic [1:0]  state_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ARMED = 2'b01,
    RUN   = 2'b10
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  val_q;
  logic        crt_q;
  logic [7:0]  duty_sh_q, duty_sh_d;
  logic [7:0]  duty_act_q, duty_act_d;
  logic [15:0] period_cnt_q, period_cnt_d;
  logic [15:0] cnt_inc;
  logic        pwm_q, pwm_d;
  logic        period_done_q, period_done_d;
  logic        wrap;

  // A wrap is only trusted when the direction is stable across the two samples.
  assign wrap = (crt == crt_q) &&
                (( crt && (val_q == 8'd255) && (val == 8'd0)) ||
                 (!crt && (val_q == 8'd0)   && (val == 8'd255)));

`ifdef COUNT_PWM_SAT_EN
  assign cnt_inc = (period_cnt_q == 16'hFFFF) ? period_cnt_q : period_cnt_q + 16'd1;
`else
  assign cnt_inc = period_cnt_q + 16'd1;
`endif

  // duty_wr is a single-cycle strobe with no back-pressure: duty_in is taken on any edge it is high.
  always_comb begin
    state_d       = state_q;
    duty_sh_d     = duty_wr ? duty_in : duty_sh_q;
    duty_act_d    = duty_act_q;
    period_cnt_d  = period_cnt_q;
    period_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (en) begin
          state_d      = ARMED;
          duty_act_d   = duty_sh_q;
          period_cnt_d = 16'd0;
        end
      end
      ARMED: begin
        if (!en) begin
          state_d = IDLE;
        end else if (wrap) begin
          state_d    = RUN;
          duty_act_d = duty_wr ? duty_in : duty_sh_q;
        end
      end
      RUN: begin
        if (!en) begin
          state_d = IDLE;
        end else if (wrap) begin
          duty_act_d    = duty_wr ? duty_in : duty_sh_q;
          period_done_d = 1'b1;
          period_cnt_d  = cnt_inc;
        end
      end
      default: state_d = IDLE;
    endcase
    // Compare against the post-edge duty so a new period starts with its new duty at val 0.
    pwm_d = ((state_d == RUN) && (val < duty_act_d)) ? POL : ~POL;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      val_q         <= 8'd0;
      crt_q         <= 1'b1;
      duty_sh_q     <= 8'd0;
      duty_act_q    <= 8'd0;
      period_cnt_q  <= 16'd0;
      pwm_q         <= ~POL;
      period_done_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      val_q         <= val;
      crt_q         <= crt;
      duty_sh_q     <= duty_sh_d;
      duty_act_q    <= duty_act_d;
      period_cnt_q  <= period_cnt_d;
      pwm_q         <= pwm_d;
      period_done_q <= period_done_d;
    end
  end

  assign pwm         = pwm_q;
  assign period_done = period_done_q;
  assign period_cnt  = period_cnt_q;
  assign state_o     = state_q;

endmodule

// File: doc/count_pwm.md
COUNT_PWM -- requirements
Module: count_pwm

Interface
REQ-001 Parameter POL, default 1'b1: active level of pwm; inactive level is ~POL.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 val  input  8  current value from the upstream 8-bit up/down counter.
REQ-005 crt  input  1  upstream counter direction: 1 = up, 0 = down.
REQ-006 en  input  1  enable; 0 forces IDLE.
REQ-007 duty_in  input  8  new duty value.
REQ-008 duty_wr  input  1  one-cycle write strobe for duty_in.
REQ-009 pwm  output  1  registered PWM output.
REQ-010 period_done  output  1  one-cycle pulse per completed counter period in RUN.
REQ-011 period_cnt  output  16  count of period_done pulses since the last arm.
REQ-012 state_o  output  2  current state: 00 IDLE, 01 ARMED, 10 RUN.

Function
REQ-013 The block SHALL register val and crt every cycle into val_q and crt_q.
REQ-014 The block SHALL detect a wrap when crt==crt_q and either (crt=1, val_q=255, val=0) or (crt=0, val_q=0, val=255).
REQ-015 The block SHALL suppress wrap detection in any cycle where crt!=crt_q.
REQ-016 duty_wr=1 SHALL load duty_in into duty_sh on the next edge.
REQ-017 IDLE->ARMED SHALL occur on the first edge with en=1; the same edge SHALL load duty_sh into duty_act and clear period_cnt to 0.
REQ-018 ARMED->RUN SHALL occur on the first wrap; period_done SHALL NOT pulse on this wrap.
REQ-019 In RUN, each wrap SHALL load duty_sh into duty_act, pulse period_done for one cycle, and increment period_cnt.
REQ-020 If duty_wr and a wrap coincide in RUN or ARMED, duty_act SHALL load duty_in directly and duty_sh SHALL also take duty_in.
REQ-021 In RUN, pwm SHALL be POL when val<duty_act, else ~POL, registered with one-cycle latency.
REQ-022 duty_act=0 SHALL give pwm constantly ~POL; duty_act=255 SHALL give POL for 255 of 256 counter values.
REQ-023 In IDLE and ARMED, pwm SHALL be ~POL and period_done SHALL be 0.
REQ-024 en=0 in any state SHALL move to IDLE on the next edge; period_cnt and duty_sh SHALL hold.
REQ-025 Direction reversal mid-period SHALL keep the RUN state, with compare continuing against the live val.

Reset
REQ-026 rst=0 SHALL immediately set state IDLE, pwm=~POL, period_done=0, period_cnt=0, duty_sh=0, duty_act=0, val_q=0, crt_q=1.
REQ-027 Release of rst SHALL take effect at the next rising clk; an operation in progress SHALL NOT resume after reset.

Configuration
REQ-028 Macro COUNT_PWM_SAT_EN defined: period_cnt SHALL saturate at 16'hFFFF.
REQ-029 COUNT_PWM_SAT_EN undefined: period_cnt SHALL wrap from 16'hFFFF to 16'h0000.

Verification
REQ-030 rst=0 mid-RUN with pwm active -> pwm=~POL, state_o=00, and period_cnt=0 before the next clk edge.
REQ-031 Bench SHALL write duty_in=64, set en=1, and count up 0..255 repeatedly -> ARMED until first 255->0 wrap, then pwm=POL for val 0..63 (one-cycle lag) and period_done each wrap.
REQ-032 Bench SHALL write duty_in=200 mid-period with duty_act=64 -> current period still uses 64; next period uses 200.
REQ-033 Bench SHALL count down (crt=0) with duty 128 -> wrap detected on 0->255 and pwm=POL for val<128.
REQ-034 Bench SHALL toggle crt at val=0 (0->1 up) -> no wrap and no period_done; duty 0 -> pwm never POL; duty 255 -> pwm=~POL only at val=255.
REQ-035 Bench SHALL preload period_cnt near 16'hFFFF via 65536 periods or force -> stays FFFF with COUNT_PWM_SAT_EN, wraps to 0000 without.
